// File: rtl/alu_seg_display.sv
// rtl/alu_seg_display.sv - registered ALU result display on two active-low 7-seg digits.
// Optional overflow blink is compiled in with `define ALU_SEG_BLINK_EN.
module alu_seg_display #(
  parameter int MIN_HOLD = 4,
  parameter int BLINK_W  = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_res,
  input  logic       in_car,
  input  logic       in_of,
  input  logic [2:0] in_ctrl,
  output logic [7:0] seg0,
  output logic [7:0] seg1
);

  typedef enum logic [1:0] {IDLE, HOLD, SHOW} state_t;
  localparam int CW = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    res_r;
  logic          car_r;
  logic          of_r;
  logic [2:0]    ctrl_r;

  logic          capture;
  logic [3:0]    res_n;
  logic          car_n;
  logic          of_n;
  logic [2:0]    ctrl_n;
  logic [3:0]    mag;
  logic [7:0]    base1;
  logic          shown;
  logic          blank_n;
  logic [7:0]    seg0_n;
  logic [7:0]    seg1_n;

  function automatic logic [7:0] digit(input logic [3:0] d);
    case (d)
      4'h0: digit = 8'hC0;  4'h1: digit = 8'hF9;
      4'h2: digit = 8'hA4;  4'h3: digit = 8'hB0;
      4'h4: digit = 8'h99;  4'h5: digit = 8'h92;
      4'h6: digit = 8'h82;  4'h7: digit = 8'hF8;
      4'h8: digit = 8'h80;  4'h9: digit = 8'h90;
      4'hA: digit = 8'h88;  4'hB: digit = 8'h83;
      4'hC: digit = 8'hC6;  4'hD: digit = 8'hA1;
      4'hE: digit = 8'h86;  default: digit = 8'h8E;
    endcase
  endfunction

  assign in_ready = (state != HOLD);
  assign capture  = in_valid && in_ready;

`ifdef ALU_SEG_BLINK_EN
  logic [BLINK_W-1:0] blink_cnt;
  logic [BLINK_W-1:0] blink_n;

  assign blink_n = capture ? '0 : blink_cnt + BLINK_W'(1);
  assign blank_n = of_n && blink_n[BLINK_W-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) blink_cnt <= '0;
    else     blink_cnt <= blink_n;
  end
`else
  wire unused_blink_w = (BLINK_W > 0);
  assign blank_n = 1'b0;
`endif

  // Outputs are computed from the values the capture registers hold after this
  // edge, so a new result appears on the very edge that captures it.
  always_comb begin
    res_n  = capture ? in_res  : res_r;
    car_n  = capture ? in_car  : car_r;
    of_n   = capture ? in_of   : of_r;
    ctrl_n = capture ? in_ctrl : ctrl_r;
    mag    = res_n;
    base1  = 8'hFF;
    if (ctrl_n[2:1] == 2'b00) begin
      if (res_n[3]) begin
        mag   = ~res_n + 4'd1;
        base1 = 8'hBF;
      end
    end
    shown  = capture || (state != IDLE);
    seg0_n = 8'hFF;
    seg1_n = 8'hFF;
    if (shown && !blank_n) begin
      seg0_n = digit(mag) & ~{of_n, 7'b0};
      seg1_n = base1      & ~{car_n, 7'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      res_r  <= '0;
      car_r  <= 1'b0;
      of_r   <= 1'b0;
      ctrl_r <= '0;
      seg0   <= 8'hFF;
      seg1   <= 8'hFF;
    end else begin
      seg0 <= seg0_n;
      seg1 <= seg1_n;
      if (capture) begin
        state  <= HOLD;
        cnt    <= CW'(MIN_HOLD - 1);
        res_r  <= in_res;
        car_r  <= in_car;
        of_r   <= in_of;
        ctrl_r <= in_ctrl;
      end else if (state == HOLD) begin
        if (cnt == '0) state <= SHOW;
        else           cnt   <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_seg_display.sv
// tb/tb_alu_seg_display.sv - vector table, corner sequences and random run vs. a behavioural model.
module tb_alu_seg_display;
  localparam int MIN_HOLD = 4;
  localparam int BLINK_W  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_res = '0;
  logic       in_car = 1'b0;
  logic       in_of = 1'b0;
  logic [2:0] in_ctrl = '0;
  logic [7:0] seg0;
  logic [7:0] seg1;

  alu_seg_display #(.MIN_HOLD(MIN_HOLD), .BLINK_W(BLINK_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_res(in_res), .in_car(in_car), .in_of(in_of), .in_ctrl(in_ctrl),
    .seg0(seg0), .seg1(seg1)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0] digits [16];

  // Reference model: what is on display and how many cycles upstream is stalled.
  bit         m_idle = 1'b1;
  logic [3:0] m_res  = '0;
  logic       m_car  = 1'b0;
  logic       m_of   = 1'b0;
  logic [2:0] m_ctrl = '0;
  int         m_hold = 0;
  int         m_age  = 0;

  typedef struct {
    logic [3:0] res;
    logic       car;
    logic       of;
    logic [2:0] ctrl;
    logic [7:0] e0;
    logic [7:0] e1;
  } vec_t;
  vec_t vecs [8];

  function automatic logic [15:0] model_seg();
    int v;
    int mag;
    logic [7:0] s0;
    logic [7:0] s1;
    if (m_idle) return 16'hFFFF;
`ifdef ALU_SEG_BLINK_EN
    if (m_of && (((m_age >> (BLINK_W - 1)) & 1) == 1)) return 16'hFFFF;
`endif
    v   = int'(m_res);
    mag = v;
    s1  = 8'hFF;
    if (m_ctrl < 3'd2) begin
      if (v >= 8) begin
        v  = v - 16;
        s1 = 8'hBF;
      end
      mag = (v < 0) ? -v : v;
    end
    s0 = digits[mag];
    if (m_of)  s0[7] = 1'b0;
    if (m_car) s1[7] = 1'b0;
    return {s1, s0};
  endfunction

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    logic [15:0] e;
    e = model_seg();
    check8({tag, ".seg0"}, seg0, e[7:0]);
    check8({tag, ".seg1"}, seg1, e[15:8]);
    check8({tag, ".ready"}, {7'b0, in_ready}, {7'b0, (m_hold == 0)});
  endtask

  task automatic model_reset();
    m_idle = 1'b1;
    m_res  = '0;
    m_car  = 1'b0;
    m_of   = 1'b0;
    m_ctrl = '0;
    m_hold = 0;
    m_age  = 0;
  endtask

  task automatic tick();
    bit cap;
    cap = (m_hold == 0) && in_valid;
    @(posedge clk);
    #1;
    if (cap) begin
      m_idle = 1'b0;
      m_res  = in_res;
      m_car  = in_car;
      m_of   = in_of;
      m_ctrl = in_ctrl;
      m_hold = MIN_HOLD;
      m_age  = 0;
    end else begin
      if (m_hold > 0) m_hold--;
      m_age++;
    end
  endtask

  task automatic drive(input logic [3:0] r, input logic c, input logic o, input logic [2:0] op);
    in_res  = r;
    in_car  = c;
    in_of   = o;
    in_ctrl = op;
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 2 * MIN_HOLD + 2 && m_hold != 0; k++) tick();
  endtask

  initial begin
    int low;
    digits = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    vecs[0] = '{4'hD, 1'b1, 1'b0, 3'b000, 8'hB0, 8'h3F};
    vecs[1] = '{4'hA, 1'b0, 1'b0, 3'b101, 8'h88, 8'hFF};
    vecs[2] = '{4'h8, 1'b1, 1'b1, 3'b000, 8'h00, 8'h3F};
    vecs[3] = '{4'h7, 1'b0, 1'b0, 3'b001, 8'hF8, 8'hFF};
    vecs[4] = '{4'hF, 1'b0, 1'b0, 3'b000, 8'hF9, 8'hBF};
    vecs[5] = '{4'h0, 1'b0, 1'b1, 3'b010, 8'h40, 8'hFF};
    vecs[6] = '{4'hF, 1'b1, 1'b0, 3'b111, 8'h8E, 8'h7F};
    vecs[7] = '{4'h9, 1'b0, 1'b1, 3'b001, 8'h78, 8'hBF};

    // Mid-cycle reset takes effect immediately.
    #2 rst = 1'b1;
    #1;
    check8("reset.seg0", seg0, 8'hFF);
    check8("reset.seg1", seg1, 8'hFF);
    check8("reset.ready", {7'b0, in_ready}, 8'h01);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    check_model("idle");

    foreach (vecs[i]) begin
      wait_ready();
      drive(vecs[i].res, vecs[i].car, vecs[i].of, vecs[i].ctrl);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check8($sformatf("vec%0d.seg0", i), seg0, vecs[i].e0);
      check8($sformatf("vec%0d.seg1", i), seg1, vecs[i].e1);
      check8($sformatf("vec%0d.ready", i), {7'b0, in_ready}, 8'h00);
    end

    // Back-to-back: valid held high, data changes right after the first capture.
    wait_ready();
    drive(4'hA, 1'b0, 1'b0, 3'b101);
    in_valid = 1'b1;
    tick();
    drive(4'h5, 1'b0, 1'b0, 3'b100);
    low = in_ready ? 0 : 1;
    for (int k = 0; k < 3 * MIN_HOLD; k++) begin
      tick();
      check_model("b2b");
      if (in_ready) break;
      low++;
    end
    check8("b2b.low_cycles", 8'(low), 8'(MIN_HOLD));
    check8("b2b.held_seg0", seg0, 8'h88);
    tick();
    check8("b2b.second_seg0", seg0, 8'h92);
    check8("b2b.second_ready", {7'b0, in_ready}, 8'h00);
    in_valid = 1'b0;

    // Overflowed result: blinks only when the feature is compiled in.
    wait_ready();
    drive(4'h8, 1'b1, 1'b1, 3'b000);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_model("blink");
    for (int k = 1; k <= 20; k++) begin
      tick();
      check_model("blink");
      if (k == 4) begin
`ifdef ALU_SEG_BLINK_EN
        check8("blink.age4_seg0", seg0, 8'hFF);
`else
        check8("blink.age4_seg0", seg0, 8'h00);
`endif
      end
    end

    // Reset during HOLD, then the still-valid pending result is taken at once.
    wait_ready();
    drive(4'h3, 1'b0, 1'b0, 3'b110);
    in_valid = 1'b1;
    tick();
    drive(4'hC, 1'b1, 1'b0, 3'b011);
    #3 rst = 1'b1;
    #1;
    check8("hold_rst.seg0", seg0, 8'hFF);
    check8("hold_rst.seg1", seg1, 8'hFF);
    check8("hold_rst.ready", {7'b0, in_ready}, 8'h01);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    in_valid = 1'b0;
    check_model("post_rst");
    check8("post_rst.seg0", seg0, 8'hC6);
    check8("post_rst.seg1", seg1, 8'h7F);

    for (int k = 0; k < 400; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      drive(4'($urandom), 1'($urandom), 1'($urandom), 3'($urandom));
      tick();
      check_model("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
